alu4_pipe: RTL and testbench

Pipelined, handshaked execution unit for the 4-bit ALU operation set. It accepts operand/opcode requests on a valid/ready input port and returns result plus c/n/z/v flags on a valid/ready output port two cycles later. It tolerates backpressure without loss or reordering. It is the responding end of the request/check flow that the ALU benches drive, and it is the sequential datapath core used by the 4-bit processor work.

---
 rtl/alu4_pkg.sv | 25 ++
 rtl/alu4_core.sv | 46 ++++
 rtl/alu4_pipe.sv | 105 ++++++++++
 tb/tb_alu4_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// alu4_pkg: shared definitions for the 4-bit ALU execution unit.
//   DATA_W         - operand/result width
//   OP_NOTA..OP_SUB - 3-bit opcode encodings
//   flags_t        - packed flag bundle {c, n, z, v}
package alu4_pkg;

  localparam int unsigned DATA_W = 4;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu4_core.sv
// alu4_core: purely combinational 4-bit ALU.
//   a_i, b_i  in  operands
//   op_i      in  opcode (see alu4_pkg)
//   result_o  out result
//   flags_o   out carry/negative/zero/overflow
module alu4_core
  import alu4_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output flags_t            flags_o
);

  logic              is_sub;
  logic              is_arith;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  always_comb begin
    is_sub   = (op_i == OP_SUB);
    is_arith = (op_i == OP_ADD) | is_sub;
    // Subtraction is a + ~b + 1, so the adder sees the inverted operand.
    b_eff    = is_sub ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

    case (op_i)
      OP_NOTA: result_o = ~a_i;
      OP_NOTB: result_o = ~b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_XNOR: result_o = ~(a_i ^ b_i);
      default: result_o = sum[DATA_W-1:0];
    endcase

    // For SUB, c = 1 means no borrow; logic ops clear c and v.
    flags_o.c = is_arith & sum[DATA_W];
    flags_o.v = is_arith & (a_i[DATA_W-1] == b_eff[DATA_W-1]) &
                (sum[DATA_W-1] != a_i[DATA_W-1]);
    flags_o.n = result_o[DATA_W-1];
    flags_o.z = (result_o == '0);
  end

endmodule

// File: rtl/alu4_pipe.sv
// alu4_pipe: two-stage valid/ready pipelined wrapper around alu4_core.
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready     request handshake; a, b, op request payload
//   out_valid/out_ready   response handshake; result, c, n, z, v payload
//   done_cnt              saturating count of output handshakes
module alu4_pipe
  import alu4_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              n,
  output logic              z,
  output logic              v,
  output logic [CNT_W-1:0]  done_cnt
);

  // Stage 1: registered request.
  logic              s1_v_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic [2:0]        s1_op_q;

  // Stage 2: registered response.
  logic              s2_v_q;
  logic [DATA_W-1:0] s2_res_q, s2_res_d;
  flags_t            s2_flags_q, s2_flags_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic s1_adv, s2_adv, out_hs;

  // Ready ripples backwards combinationally so a full pipe can accept and
  // emit in the same cycle.
  always_comb begin
    s2_adv   = ~s2_v_q | out_ready;
    s1_adv   = ~s1_v_q | s2_adv;
    in_ready = s1_adv;
    out_hs   = s2_v_q & out_ready;
    cnt_d    = cnt_q;
    if (out_hs && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  alu4_core u_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (s2_res_d),
    .flags_o  (s2_flags_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_op_q <= '0;
    end else if (s1_adv) begin
      s1_v_q  <= in_valid;
      s1_a_q  <= a;
      s1_b_q  <= b;
      s1_op_q <= op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_v_q     <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '{c: 1'b0, n: 1'b0, z: 1'b1, v: 1'b0};
    end else if (s2_adv) begin
      s2_v_q     <= s1_v_q;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_v_q;
  assign result    = s2_res_q;
  assign c         = s2_flags_q.c;
  assign n         = s2_flags_q.n;
  assign z         = s2_flags_q.z;
  assign v         = s2_flags_q.v;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_alu4_pipe.sv
// tb_alu4_pipe: directed table-driven bench for alu4_pipe with a response
// scoreboard; a second instance with CNT_W=2 checks counter saturation.
module tb_alu4_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready;
  logic [3:0] a, b;
  logic [2:0] op;
  logic       in_ready, out_valid, c, n, z, v;
  logic [3:0] result;
  logic [7:0] done_cnt;
  logic       in_ready2, out_valid2, c2, n2, z2, v2;
  logic [3:0] result2;
  logic [1:0] done_cnt2;

  always #5 clk = ~clk;

  alu4_pipe #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c(c), .n(n), .z(z), .v(v), .done_cnt(done_cnt)
  );

  alu4_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .c(c2), .n(n2), .z(z2), .v(v2), .done_cnt(done_cnt2)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       c, n, z, v;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  vec_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic drive(input vec_t e, input logic vld);
    in_valid = vld;
    a        = e.a;
    b        = e.b;
    op       = e.op;
  endtask

  // One cycle: called at posedge+1 with inputs driven; scoreboards the
  // handshakes of this cycle, then returns at the next posedge+1.
  task automatic tick(input vec_t e);
    logic acc, cons;
    vec_t x;
    #1;
    acc  = in_valid & in_ready;
    cons = out_valid & out_ready;
    if (cons) begin
      if (exp_q.size() == 0) begin
        chk("stale_response", 1, 0);
      end else begin
        x = exp_q.pop_front();
        chk("result", int'(result), int'(x.res));
        chk("flags", int'({c, n, z, v}), int'({x.c, x.n, x.z, x.v}));
      end
    end
    if (acc) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (cons) hs_cnt++;
    chk("done_cnt", int'(done_cnt), (hs_cnt > 255) ? 255 : hs_cnt);
    chk("done_cnt_sat", int'(done_cnt2), (hs_cnt > 3) ? 3 : hs_cnt);
  endtask

  initial begin
    vec_t idle;
    logic [3:0] held;

    //          a        b        op      res      c     n     z     v
    vecs[0]  = '{4'b0111, 4'b0001, 3'b110, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{4'b0011, 4'b0011, 3'b111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0010, 4'b0101, 3'b111, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'b1010, 4'b0110, 3'b000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b1010, 4'b0110, 3'b001, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{4'b1010, 4'b0110, 3'b010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b1010, 4'b0110, 3'b011, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'b1010, 4'b0110, 3'b100, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'b1010, 4'b0110, 3'b101, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0};
    // Opposite signs: carry out but no overflow.
    vecs[9]  = '{4'b1010, 4'b0110, 3'b110, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'b1010, 4'b0110, 3'b111, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'b1000, 4'b1000, 3'b110, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{4'b0000, 4'b0001, 3'b111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0};
    idle = vecs[0];

    // Reset state.
    reset = 1'b1; out_ready = 1'b1;
    drive(idle, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({c, n, z, v}), 4'b0010);
    chk("rst_done_cnt", int'(done_cnt), 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    // Latency: accept at edge k, out_valid only after edge k+1.
    drive(vecs[0], 1'b1);
    tick(vecs[0]);
    drive(idle, 1'b0);
    chk("lat_after_k", int'(out_valid), 0);
    tick(idle);
    chk("lat_after_k1", int'(out_valid), 1);
    tick(idle);

    // Full-rate stream of the remaining vectors.
    for (int i = 1; i < NV; i++) begin
      drive(vecs[i], 1'b1);
      tick(vecs[i]);
    end
    drive(idle, 1'b0);
    for (int i = 0; i < 3; i++) tick(idle);
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure: only two accepted, third held off.
    out_ready = 1'b0;
    drive(vecs[3], 1'b1); tick(vecs[3]);
    drive(vecs[4], 1'b1); tick(vecs[4]);
    drive(vecs[5], 1'b1);
    held = result;
    chk("bp_head", int'(held), int'(vecs[3].res));
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_hold", int'(result), int'(held));
      tick(vecs[5]);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 1);
    tick(vecs[5]);
    // Accept and consume together: still two in flight.
    drive(idle, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("occ_two", int'(in_ready), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(idle);
    chk("bp_drained", exp_q.size(), 0);
    chk("sat_final", int'(done_cnt2), 3);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    drive(vecs[0], 1'b1); tick(vecs[0]);
    drive(vecs[1], 1'b1); tick(vecs[1]);
    drive(idle, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_done_cnt", int'(done_cnt), 0);
    chk("mid_rst_z", int'(z), 1);
    chk("mid_rst_result", int'(result), 0);
    exp_q.delete();
    hs_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(idle);
      chk("post_rst_quiet", int'(out_valid), 0);
    end
    drive(vecs[2], 1'b1); tick(vecs[2]);
    drive(idle, 1'b0);
    for (int i = 0; i < 3; i++) tick(idle);
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
